// File: rtl/menu_config_controller.sv
// Rotary-encoder menu: debounces ENTER, runs browse/edit/commit over a
// small bank of configuration words and strobes each committed write.
module menu_config_controller #(
    parameter int NUM_REGS   = 4,
    parameter int DATA_W     = 8,
    parameter int MAX_VAL    = 200,
    parameter int DEB_CYCLES = 50000,
    parameter int TIMEOUT    = 1 << 24
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         UP,
    input  logic                         DOWN,
    input  logic                         ENTER,
    output logic [$clog2(NUM_REGS)-1:0]  SEL,
    output logic                         EDIT_MODE,
    output logic [DATA_W-1:0]            SHOW_VAL,
    output logic                         WR_EN,
    output logic [$clog2(NUM_REGS)-1:0]  WR_ADDR,
    output logic [DATA_W-1:0]            WR_DATA,
    output logic [NUM_REGS*DATA_W-1:0]   CFG_OUT
);

    localparam int SW = $clog2(NUM_REGS);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [DW-1:0]     DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] MAXV     = DATA_W'(MAX_VAL);

    typedef enum logic [1:0] {BROWSE, EDIT, COMMIT} state_t;

    state_t                           state_q;
    logic [SW-1:0]                    sel_q;
    logic [DATA_W-1:0]                work_q;
    logic [TW-1:0]                    idle_q;
    logic                             edit_q;
    logic                             wr_en_q;
    logic [SW-1:0]                    wr_addr_q;
    logic [DATA_W-1:0]                wr_data_q;
    logic [NUM_REGS-1:0][DATA_W-1:0]  cfg_q;

    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          acc_q, acc_d;
    logic          press_q, press_d;

    logic step_up, step_dn;

    assign step_up = UP & ~DOWN;
    assign step_dn = DOWN & ~UP;

    // A level change is accepted only after DEB_CYCLES consecutive cycles.
    always_comb begin
        deb_cnt_d = '0;
        acc_d     = acc_q;
        press_d   = 1'b0;
        if (ENTER != acc_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                acc_d   = ENTER;
                press_d = ENTER;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            deb_cnt_q <= '0;
            acc_q     <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            acc_q     <= acc_d;
            press_q   <= press_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= BROWSE;
            sel_q     <= '0;
            work_q    <= '0;
            idle_q    <= '0;
            edit_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cfg_q     <= '0;
        end else begin
            wr_en_q <= 1'b0;
            unique case (state_q)
                BROWSE: begin
                    if (press_q) begin
                        work_q  <= cfg_q[sel_q];
                        idle_q  <= '0;
                        edit_q  <= 1'b1;
                        state_q <= EDIT;
                    end else if (step_up) begin
                        sel_q <= sel_q + SW'(1);
                    end else if (step_dn) begin
                        sel_q <= sel_q - SW'(1);
                    end
                end
                EDIT: begin
                    if (press_q) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= sel_q;
                        wr_data_q <= work_q;
                        edit_q    <= 1'b0;
                        state_q   <= COMMIT;
                    end else if (UP | DOWN) begin
                        idle_q <= '0;
                        if (step_up && work_q < MAXV) begin
                            work_q <= work_q + DATA_W'(1);
                        end else if (step_dn && work_q != '0) begin
                            work_q <= work_q - DATA_W'(1);
                        end
                    end else if (idle_q == TO_LAST) begin
                        edit_q  <= 1'b0;
                        state_q <= BROWSE;
                    end else begin
                        idle_q <= idle_q + TW'(1);
                    end
                end
                COMMIT: begin
                    cfg_q[sel_q] <= work_q;
                    state_q      <= BROWSE;
                end
                default: begin
                    edit_q  <= 1'b0;
                    state_q <= BROWSE;
                end
            endcase
        end
    end

    assign SEL       = sel_q;
    assign EDIT_MODE = edit_q;
    assign SHOW_VAL  = edit_q ? work_q : cfg_q[sel_q];
    assign WR_EN     = wr_en_q;
    assign WR_ADDR   = wr_addr_q;
    assign WR_DATA   = wr_data_q;
    assign CFG_OUT   = cfg_q;

endmodule

// File: tb/tb_menu_config_controller.sv
// Directed and randomized checks of menu_config_controller against a
// cycle-level behavioural model of the menu rules.
module tb_menu_config_controller;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int MAXV = 200;
    localparam int DEB  = 4;
    localparam int TO   = 16;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          UP, DOWN, ENTER;
    logic [1:0]    SEL;
    logic          EDIT_MODE;
    logic [7:0]    SHOW_VAL;
    logic          WR_EN;
    logic [1:0]    WR_ADDR;
    logic [7:0]    WR_DATA;
    logic [31:0]   CFG_OUT;

    menu_config_controller #(
        .NUM_REGS(N), .DATA_W(DW), .MAX_VAL(MAXV),
        .DEB_CYCLES(DEB), .TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .UP(UP), .DOWN(DOWN), .ENTER(ENTER),
        .SEL(SEL), .EDIT_MODE(EDIT_MODE), .SHOW_VAL(SHOW_VAL),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .CFG_OUT(CFG_OUT)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Model: mode 0=browse, 1=edit, 2=commit
    int m_mode, m_sel, m_work, m_idle, m_run, m_wa, m_wd;
    int m_cfg[N];
    bit m_acc, m_press;

    int wr_count = 0;
    int last_addr = 0, last_data = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_sel = 0; m_work = 0; m_idle = 0; m_run = 0;
        m_wa = 0; m_wd = 0; m_acc = 0; m_press = 0;
        for (int i = 0; i < N; i++) m_cfg[i] = 0;
    endtask

    task automatic model_step(input logic u, input logic d, input logic e);
        bit pr = m_press;
        bit su = u && !d;
        bit sd = d && !u;
        m_press = 0;
        if (e != m_acc) begin
            m_run++;
            if (m_run == DEB) begin
                m_acc = e; m_run = 0; m_press = e;
            end
        end else m_run = 0;
        case (m_mode)
            0: begin
                if (pr) begin
                    m_work = m_cfg[m_sel]; m_mode = 1; m_idle = 0;
                end else if (su) m_sel = (m_sel + 1) % N;
                else if (sd) m_sel = (m_sel + N - 1) % N;
            end
            1: begin
                if (pr) begin
                    m_mode = 2; m_wa = m_sel; m_wd = m_work;
                end else if (u || d) begin
                    m_idle = 0;
                    if (su && m_work < MAXV) m_work++;
                    if (sd && m_work > 0) m_work--;
                end else if (m_idle == TO - 1) m_mode = 0;
                else m_idle++;
            end
            default: begin
                m_cfg[m_sel] = m_work; m_mode = 0;
            end
        endcase
    endtask

    task automatic check_all();
        logic [31:0] exp_cfg;
        for (int i = 0; i < N; i++) exp_cfg[i*DW +: DW] = 8'(m_cfg[i]);
        chk("sel", 64'(SEL), 64'(m_sel));
        chk("edit_mode", 64'(EDIT_MODE), 64'(m_mode == 1));
        chk("show_val", 64'(SHOW_VAL),
            64'(m_mode == 1 ? m_work : m_cfg[m_sel]));
        chk("wr_en", 64'(WR_EN), 64'(m_mode == 2));
        chk("cfg_out", 64'(CFG_OUT), 64'(exp_cfg));
        if (m_mode == 2) begin
            chk("wr_addr", 64'(WR_ADDR), 64'(m_wa));
            chk("wr_data", 64'(WR_DATA), 64'(m_wd));
        end
        if (WR_EN === 1'b1) begin
            wr_count++; last_addr = int'(WR_ADDR); last_data = int'(WR_DATA);
        end
    endtask

    task automatic cycle(input logic u, input logic d, input logic e);
        UP = u; DOWN = d; ENTER = e;
        @(posedge CLK);
        model_step(u, d, e);
        @(negedge CLK);
        check_all();
    endtask

    // Hold ENTER until the press is accepted, optionally with UP on the
    // press cycle, then release long enough for the level to settle low.
    task automatic press(input logic up_on_press);
        for (int i = 0; i < DEB; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(up_on_press, 1'b0, 1'b1);
        for (int i = 0; i <= DEB; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_sel[5] = '{3, 2, 1, 0, 3};
        int first, rises, wc0;
        logic prev, e;

        RST_N = 1'b0; UP = 1'b0; DOWN = 1'b0; ENTER = 1'b0;
        model_reset();
        @(negedge CLK); @(negedge CLK);
        chk("rst_sel", 64'(SEL), 64'd0);
        chk("rst_edit", 64'(EDIT_MODE), 64'd0);
        chk("rst_wr_en", 64'(WR_EN), 64'd0);
        chk("rst_cfg", 64'(CFG_OUT), 64'd0);
        RST_N = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            chk("down_seq", 64'(SEL), 64'(exp_sel[i]));
        end

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0);
        chk("bounce_no_press", 64'(EDIT_MODE), 64'd0);

        first = 0; rises = 0; prev = EDIT_MODE;
        for (int k = 1; k <= 26; k++) begin
            cycle(1'b0, 1'b0, k <= 20);
            if (EDIT_MODE && !prev) rises++;
            if (EDIT_MODE && first == 0) first = k;
            prev = EDIT_MODE;
        end
        chk("press_latency", 64'(first), 64'(DEB + 1));
        chk("single_press", 64'(rises), 64'd1);

        cycle(1'b0, 1'b1, 1'b0);
        chk("sel_two", 64'(SEL), 64'd2);
        wc0 = wr_count;
        press(1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0);
        press(1'b0);
        chk("commit_count", 64'(wr_count - wc0), 64'd1);
        chk("commit_addr", 64'(last_addr), 64'd2);
        chk("commit_data", 64'(last_data), 64'd7);
        chk("commit_cfg", 64'(CFG_OUT), 64'h0007_0000);
        chk("commit_edit", 64'(EDIT_MODE), 64'd0);

        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        press(1'b0);
        for (int i = 0; i < 198; i++) cycle(1'b1, 1'b0, 1'b0);
        press(1'b0);
        press(1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
        chk("sat_max", 64'(SHOW_VAL), 64'd200);
        for (int i = 0; i < 250; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("sat_min", 64'(SHOW_VAL), 64'd0);
        press(1'b0);

        press(1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        wc0 = wr_count;
        for (int i = 0; i < TO - 1; i++) cycle(1'b0, 1'b0, 1'b0);
        chk("timeout_before", 64'(EDIT_MODE), 64'd1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("timeout_after", 64'(EDIT_MODE), 64'd0);
        chk("timeout_no_wr", 64'(wr_count - wc0), 64'd0);
        chk("timeout_cfg", 64'(CFG_OUT), 64'h0007_0000);

        press(1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("up_down_cancel", 64'(SHOW_VAL), 64'd2);
        press(1'b1);
        chk("press_beats_up", 64'(last_data), 64'd2);
        chk("press_up_cfg", 64'(CFG_OUT), 64'h0007_0002);

        press(1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        RST_N = 1'b0;
        #1;
        chk("async_sel", 64'(SEL), 64'd0);
        chk("async_edit", 64'(EDIT_MODE), 64'd0);
        chk("async_show", 64'(SHOW_VAL), 64'd0);
        chk("async_wr_en", 64'(WR_EN), 64'd0);
        chk("async_wr_addr", 64'(WR_ADDR), 64'd0);
        chk("async_wr_data", 64'(WR_DATA), 64'd0);
        chk("async_cfg", 64'(CFG_OUT), 64'd0);
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;

        e = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) e = ~e;
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
